aes_inv_sub_seq: RTL

Sequenced InvSubBytes engine for the decryption path. It accepts a 128-bit state and pushes its 16 bytes through NSB shared `aes_inv_sbox` instances over 16/NSB cycles, then presents the substituted 128-bit state. It sits between the inverse-round datapath and the inverse S-box ROMs, so area can be traded against throughput with one parameter.

---
 rtl/aes_inv_sub_seq_if.sv | 26 ++
 rtl/aes_inv_sub_seq.sv | 100 ++++++++++
 2 files changed

// File: rtl/aes_inv_sub_seq_if.sv
// aes_inv_sub_seq_if: handshake bundle between a producer/consumer and the InvSubBytes sequencer
// Signals:
//   clr        synchronous flush toward the engine
//   in_valid   in_data is offered; in_ready is the engine's acceptance
//   in_data    128-bit state, byte 0 in the MSBs
//   out_valid  out_data holds a finished result; out_ready is the consumer's take
//   out_data   substituted 128-bit state
//   busy       engine is substituting or holding a result
interface aes_inv_sub_seq_if;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    modport master (
        output clr, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
    modport slave (
        input  clr, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_inv_sub_seq.sv
// aes_inv_sub_seq: InvSubBytes over a 128-bit state using NSB shared inverse S-boxes in 16/NSB passes
// aes_inv_sbox ports: a (8-bit address), y (8-bit inverse S-box value)
// aes_inv_sub_seq ports:
//   clk, rst   clock and asynchronous active-high reset
//   bus        aes_inv_sub_seq_if.slave: clr, in_valid/in_ready/in_data, out_valid/out_ready/out_data, busy
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) r = r ^ p;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction
    // Multiplicative inverse as x^254; zero maps to zero naturally
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction
    logic [7:0] b;
    // Inverse affine transform precedes the field inversion
    assign b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    assign y = ginv(b);
endmodule

module aes_inv_sub_seq #(
    parameter int NSB = 4
) (
    input logic             clk,
    input logic             rst,
    aes_inv_sub_seq_if.slave bus
);
    localparam int P  = 16 / NSB;
    localparam int CW = (P > 1) ? $clog2(P) : 1;
    typedef enum logic [1:0] {IDLE, SUB, HOLD} state_t;
    state_t         state;
    state_t         state_nx;
    logic [127:0]   src;
    logic [127:0]   dst;
    logic [127:0]   dst_nx;
    logic [CW-1:0]  cnt;
    logic           accept;
    logic           last;
    logic [7:0]     sb_in  [NSB];
    logic [7:0]     sb_out [NSB];
    if (!(NSB == 1 || NSB == 2 || NSB == 4 || NSB == 8 || NSB == 16)) begin : g_bad_nsb
        $error("aes_inv_sub_seq: NSB must be 1, 2, 4, 8 or 16");
    end
    for (genvar g = 0; g < NSB; g++) begin : g_sb
        aes_inv_sbox u_sb (.a(sb_in[g]), .y(sb_out[g]));
    end
    assign bus.out_data = dst;
    always_comb begin
        bus.in_ready  = !bus.clr && (state == IDLE || (state == HOLD && bus.out_ready));
        bus.out_valid = state == HOLD;
        bus.busy      = state != IDLE;
        accept        = bus.in_valid && bus.in_ready;
        last          = cnt == CW'(P - 1);
        state_nx      = bus.clr ? IDLE :
                        accept ? SUB :
                        (state == SUB && last) ? HOLD :
                        (state == HOLD && bus.out_ready) ? IDLE : state;
    end
    // Lane j of pass cnt handles byte cnt*NSB+j; byte k sits at bit offset 120-8k
    always_comb begin
        dst_nx = dst;
        for (int j = 0; j < NSB; j++) begin
            sb_in[j] = 8'(src >> (120 - 8 * (int'(cnt) * NSB + j)));
            dst_nx   = (dst_nx & ~(128'hff << (120 - 8 * (int'(cnt) * NSB + j))))
                     | (128'(sb_out[j]) << (120 - 8 * (int'(cnt) * NSB + j)));
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            src   <= '0;
            dst   <= '0;
        end else begin
            state <= state_nx;
            if (bus.clr || accept || (state == SUB && last)) cnt <= '0;
            else if (state == SUB) cnt <= cnt + CW'(1);
            if (accept) src <= bus.in_data;
            if (state == SUB && !bus.clr) dst <= dst_nx;
        end
    end
endmodule
